// File: rtl/seq_tx_pkg.sv
// Shared definitions for the seq_pattern_tx serial bit-pattern transmitter:
// state encoding, default sizing constants and the preamble word.
package seq_tx_pkg;

   localparam int STATE_W     = 3;
   localparam int PAT_W_DEF   = 8;
   localparam int GAP_CYC_DEF = 2;
   localparam int REP_W_DEF   = 4;

   // Sent MSB first ahead of every frame when the preamble build is enabled
   localparam logic [1:0] PREAMBLE = 2'b10;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_SEND = 3'd1,
      ST_GAP  = 3'd2,
      ST_DONE = 3'd3,
      ST_PRE  = 3'd4
   } state_e;

endpackage

// File: rtl/seq_tx_shreg.sv
// Left-shift register with parallel load; the MSB is the serial output.
// A load wins over a shift in the same cycle, and zeros enter at the LSB.
module seq_tx_shreg #(
   parameter int PAT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [PAT_W-1:0] load_val_i,
   output logic             msb_o
);

   logic [PAT_W-1:0] sh_q;
   logic [PAT_W-1:0] sh_d;

   // next contents: load, shift or hold
   always_comb begin
      sh_d = sh_q;
      if (load_i) begin
         sh_d = load_val_i;
      end else if (shift_i) begin
         sh_d = {sh_q[PAT_W-2:0], 1'b0};
      end else begin
         sh_d = sh_q;
      end
   end

   // shift register storage
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh_q <= '0;
      end else begin
         sh_q <= sh_d;
      end
   end

   assign msb_o = sh_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a captured pattern MSB-first on w,
// optionally repeated with idle gaps. Define SEQ_TX_PREAMBLE_EN to prefix
// every frame (including each repetition) with a two-bit preamble.
module seq_pattern_tx
   import seq_tx_pkg::*;
#(
   parameter int PAT_W   = PAT_W_DEF,
   parameter int GAP_CYC = GAP_CYC_DEF,
   parameter int REP_W   = REP_W_DEF
) (
   input  logic                         Clock,
   input  logic                         R,
   input  logic                         Start,
   input  logic                         Abort,
   input  logic [PAT_W-1:0]             Pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   Len,
   input  logic [REP_W-1:0]             Reps,
   output logic                         w,
   output logic                         Valid,
   output logic                         Busy,
   output logic                         Done
);

   localparam int LEN_W  = $clog2(PAT_W + 1);
   localparam int GAP_CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

`ifdef SEQ_TX_PREAMBLE_EN
   localparam state_e ST_FRAME = ST_PRE;
`else
   localparam state_e ST_FRAME = ST_SEND;
`endif

   state_e              state_q, state_d;
   logic [PAT_W-1:0]    pat_q, pat_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [REP_W-1:0]    reps_q, reps_d;
   logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
   logic [LEN_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GAP_CW-1:0]   gap_cnt_q, gap_cnt_d;
`ifdef SEQ_TX_PREAMBLE_EN
   logic                pre_cnt_q, pre_cnt_d;
`endif

   logic [LEN_W-1:0]    eff_len_s;
   logic [PAT_W-1:0]    aligned_s;
   logic                sh_load_s;
   logic                sh_shift_s;
   logic [PAT_W-1:0]    sh_load_val_s;
   logic                sh_msb_s;

   assign eff_len_s = ((Len == '0) || (Len > LEN_W'(PAT_W))) ? LEN_W'(PAT_W) : Len;
   assign aligned_s = Pattern << (LEN_W'(PAT_W) - eff_len_s);

   seq_tx_shreg #(
      .PAT_W (PAT_W)
   ) u_shreg (
      .clk_i      (Clock),
      .rst_ni     (R),
      .load_i     (sh_load_s),
      .shift_i    (sh_shift_s),
      .load_val_i (sh_load_val_s),
      .msb_o      (sh_msb_s)
   );

   // next-state, counter and shift-control logic
   always_comb begin
      state_d       = state_q;
      pat_d         = pat_q;
      len_d         = len_q;
      reps_d        = reps_q;
      rep_cnt_d     = rep_cnt_q;
      bit_cnt_d     = bit_cnt_q;
      gap_cnt_d     = gap_cnt_q;
`ifdef SEQ_TX_PREAMBLE_EN
      pre_cnt_d     = pre_cnt_q;
`endif
      sh_load_s     = 1'b0;
      sh_shift_s    = 1'b0;
      sh_load_val_s = pat_q;

      if (Abort && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         rep_cnt_d = '0;
         bit_cnt_d = '0;
         gap_cnt_d = '0;
`ifdef SEQ_TX_PREAMBLE_EN
         pre_cnt_d = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Abort in IDLE suppresses a capture
               if (Start && !Abort) begin
                  pat_d         = aligned_s;
                  len_d         = eff_len_s;
                  reps_d        = Reps;
                  rep_cnt_d     = '0;
                  bit_cnt_d     = '0;
                  sh_load_s     = 1'b1;
                  sh_load_val_s = aligned_s;
                  state_d       = ST_FRAME;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SEND: begin
               sh_shift_s = 1'b1;
               if (bit_cnt_q == (len_q - LEN_W'(1))) begin
                  bit_cnt_d = '0;
                  if (rep_cnt_q < reps_q) begin
                     rep_cnt_d = rep_cnt_q + REP_W'(1);
                     if (GAP_CYC > 0) begin
                        gap_cnt_d = '0;
                        state_d   = ST_GAP;
                     end else begin
                        sh_load_s = 1'b1;
                        state_d   = ST_FRAME;
                     end
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + LEN_W'(1);
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_CW'(GAP_CYC - 1)) begin
                  gap_cnt_d = '0;
                  sh_load_s = 1'b1;
                  state_d   = ST_FRAME;
               end else begin
                  gap_cnt_d = gap_cnt_q + GAP_CW'(1);
               end
            end
`ifdef SEQ_TX_PREAMBLE_EN
            ST_PRE: begin
               if (pre_cnt_q) begin
                  pre_cnt_d = 1'b0;
                  state_d   = ST_SEND;
               end else begin
                  pre_cnt_d = 1'b1;
               end
            end
`endif
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // state, holding registers and counters
   always_ff @(posedge Clock or negedge R) begin
      if (!R) begin
         state_q   <= ST_IDLE;
         pat_q     <= '0;
         len_q     <= '0;
         reps_q    <= '0;
         rep_cnt_q <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
`ifdef SEQ_TX_PREAMBLE_EN
         pre_cnt_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pat_q     <= pat_d;
         len_q     <= len_d;
         reps_q    <= reps_d;
         rep_cnt_q <= rep_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
`ifdef SEQ_TX_PREAMBLE_EN
         pre_cnt_q <= pre_cnt_d;
`endif
      end
   end

   // Moore outputs decoded from registered state only
   always_comb begin
      w     = 1'b0;
      Valid = 1'b0;
      Busy  = (state_q != ST_IDLE);
      Done  = (state_q == ST_DONE);
      case (state_q)
         ST_SEND: begin
            w     = sh_msb_s;
            Valid = 1'b1;
         end
`ifdef SEQ_TX_PREAMBLE_EN
         ST_PRE: begin
            w     = pre_cnt_q ? PREAMBLE[0] : PREAMBLE[1];
            Valid = 1'b1;
         end
`endif
         default: begin
            w     = 1'b0;
            Valid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: directed and random frames compared
// cycle by cycle against a frame-level model built from the transmit rules.
module tb_seq_pattern_tx;

   localparam int PAT_W   = 8;
   localparam int GAP_CYC = 2;
   localparam int REP_W   = 4;
   localparam int LEN_W   = $clog2(PAT_W + 1);
`ifdef SEQ_TX_PREAMBLE_EN
   localparam int PRE_LEN = 2;
`else
   localparam int PRE_LEN = 0;
`endif

   logic             Clock = 1'b0;
   logic             R = 1'b0;
   logic             Start = 1'b0;
   logic             Abort = 1'b0;
   logic [PAT_W-1:0] Pattern = '0;
   logic [LEN_W-1:0] Len = '0;
   logic [REP_W-1:0] Reps = '0;
   logic             w, Valid, Busy, Done;

   int n_assert = 0;
   int n_fail   = 0;

   // expected {w, Valid, Busy, Done} per cycle after the Start edge
   logic [3:0] exp_q[$];

   seq_pattern_tx #(
      .PAT_W   (PAT_W),
      .GAP_CYC (GAP_CYC),
      .REP_W   (REP_W)
   ) dut (
      .Clock   (Clock),
      .R       (R),
      .Start   (Start),
      .Abort   (Abort),
      .Pattern (Pattern),
      .Len     (Len),
      .Reps    (Reps),
      .w       (w),
      .Valid   (Valid),
      .Busy    (Busy),
      .Done    (Done)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [3:0] expv);
      logic [3:0] obs;
      obs = {w, Valid, Busy, Done};
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed {w,Valid,Busy,Done}=%b expected %b", tag, obs, expv);
      end
   endtask

   // frame-level model: preamble, bits high to low, gaps, Done, then idle
   task automatic build_model(input logic [PAT_W-1:0] pat, input int len, input int reps);
      int l;
      l = ((len == 0) || (len > PAT_W)) ? PAT_W : len;
      exp_q.delete();
      for (int r = 0; r <= reps; r++) begin
         if (PRE_LEN == 2) begin
            exp_q.push_back(4'b1110);
            exp_q.push_back(4'b0110);
         end
         for (int i = l - 1; i >= 0; i--) exp_q.push_back({pat[i], 3'b110});
         if (r < reps) for (int g = 0; g < GAP_CYC; g++) exp_q.push_back(4'b0010);
      end
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0000);
   endtask

   // caller sits 1 time unit after a posedge with the DUT idle; returns in
   // the trailing idle cycle so the next frame can start back-to-back
   task automatic run_frame(input string tag, input logic [PAT_W-1:0] pat,
                            input int len, input int reps);
      build_model(pat, len, reps);
      Start = 1'b1; Pattern = pat; Len = LEN_W'(len); Reps = REP_W'(reps);
      @(posedge Clock); #1;
      for (int k = 0; k < exp_q.size(); k++) begin
         check(tag, exp_q[k]);
         if (k == exp_q.size() - 1) begin
            Start = 1'b0;
         end else begin
            Start   = 1'($urandom_range(0, 1));
            Pattern = PAT_W'($urandom);
            Len     = LEN_W'($urandom);
            Reps    = REP_W'($urandom);
            @(posedge Clock); #1;
         end
      end
   endtask

   initial begin
      logic [PAT_W-1:0] p;
      // reset state
      #2;
      check("reset_hold", 4'b0000);
      @(posedge Clock); #1;
      R = 1'b1;
      @(posedge Clock); #1;
      check("idle_after_reset", 4'b0000);

      // short frame, then back-to-back restart and the full-length default
      run_frame("len4_once", 8'b0000_1011, 4, 0);
      run_frame("a5_len0_reps2", 8'hA5, 0, 2);
      run_frame("len1", 8'h01, 1, 1);
      run_frame("len_over", 8'h3C, 13, 0);
`ifdef SEQ_TX_PREAMBLE_EN
      run_frame("pre_len3", 8'b0000_0111, 3, 1);
`endif

      // abort on the third data bit of a full-length frame
      p = 8'hD6;
      build_model(p, 8, 0);
      Start = 1'b1; Pattern = p; Len = LEN_W'(8); Reps = '0;
      @(posedge Clock); #1;
      Start = 1'b0;
      for (int k = 0; k <= PRE_LEN + 2; k++) begin
         check("abort_pre", exp_q[k]);
         if (k == PRE_LEN + 2) Abort = 1'b1;
         @(posedge Clock); #1;
      end
      Abort = 1'b0;
      check("abort_idle", 4'b0000);
      @(posedge Clock); #1;
      check("abort_no_done", 4'b0000);

      // Abort wins over Start while idle
      Start = 1'b1; Abort = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0; Abort = 1'b0;
      check("abort_beats_start", 4'b0000);
      run_frame("after_abort", 8'h5A, 6, 1);

      // asynchronous reset in the middle of a frame
      Start = 1'b1; Pattern = 8'hFF; Len = LEN_W'(8); Reps = REP_W'(3);
      @(posedge Clock); #1;
      Start = 1'b0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      check("pre_reset_active", 4'b1110);
      #2 R = 1'b0;
      #1 check("async_reset", 4'b0000);
      #1 R = 1'b1;
      @(posedge Clock); #1;
      check("idle_after_midreset", 4'b0000);

      // random frames
      for (int n = 0; n < 25; n++) begin
         run_frame("random", PAT_W'($urandom), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial bit-pattern transmitter. It is the driving end of the single-bit serial line (w) that the team's Moore sequence-detector FSMs consume.
- Loads a pattern word and a bit length, shifts the pattern out MSB-first one bit per Clock, and optionally repeats it with idle gaps.
- Used as stimulus source and on-chip pattern generator for the detector blocks.

Parameters:
PAT_W, 8, maximum pattern length in bits (≥2)
GAP_CYC, 2, idle cycles (w=0, Valid=0) between repetitions; 0 = back-to-back
REP_W, 4, width of repeat-count input

Ports:
Clock  input  1  system clock; all state updates on posedge
R  input  1  reset, asynchronous, active-low (R=0 resets immediately)
Start  input  1  request to send; sampled only in IDLE
Abort  input  1  synchronous abort; highest priority after reset
Pattern  input  PAT_W  bits to send; Pattern[Len-1] is sent first
Len  input  clog2(PAT_W+1)  bits per frame; 0 or >PAT_W treated as PAT_W
Reps  input  REP_W  additional repetitions (0 = send once)
w  output  1  serial data line
Valid  output  1  high while w carries a pattern bit
Busy  output  1  high in every state except IDLE
Done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- Moore machine: all outputs are registered or decoded from state only; no combinational input-to-output path.
- Reset (R=0, async): state=IDLE, w=0, Valid=0, Busy=0, Done=0, shift register, bit counter, rep counter and gap counter all 0. Reset mid-frame truncates the frame immediately.
- States: IDLE, SEND, GAP, DONE (plus PRE with the optional feature).
- IDLE:
  - On the posedge with Start=1, capture Pattern, the effective Len, and Reps into holding registers.
  - Load the shift register with Pattern left-aligned (Pattern << (PAT_W-Len)) and go to SEND.
  - Latency: Start sampled at edge k → first bit on w from edge k+1.
- SEND:
  - w = shift_reg MSB, Valid=1; shift left one bit per cycle.
  - Bit counter counts Len bits.
  - After the last bit:
    - rep counter < captured Reps: increment it; go to GAP if GAP_CYC>0, else reload the shift register and stay in SEND (no bubble).
    - otherwise go to DONE.
- GAP: w=0, Valid=0 for exactly GAP_CYC cycles. Then reload the shift register from the holding register and return to SEND.
- DONE: Done=1, Busy=1, w=0, Valid=0 for one cycle, then IDLE. If Start=1 in the following IDLE cycle, a new frame begins (no lockout beyond one IDLE cycle).
- Start outside IDLE is ignored. Pattern/Len/Reps changes after capture are ignored.
- Abort=1 in any non-IDLE state: next edge → IDLE, w=0, Valid=0, no Done pulse. Abort in IDLE has priority over Start (no capture).
- Len=1: one-cycle frame. Len=PAT_W: no shift alignment.
- Total cycles Start→Done = (Reps+1)*Len + Reps*GAP_CYC + 1 (plus preamble, if enabled).

Optional Feature:
Macro SEQ_TX_PREAMBLE_EN.
- Defined: adds localparam PREAMBLE=2'b10 and a PRE state entered before every SEND, including each repetition after GAP.
  - PRE emits 1 then 0 on w with Valid=1; then SEND begins.
  - Cycle total gains 2*(Reps+1).
- Undefined: the PRE state and preamble logic are absent; IDLE/GAP go directly to SEND.

Decomposition:
- Package seq_tx_pkg: state encoding (IDLE=0, SEND=1, GAP=2, DONE=3, PRE=4), 3-bit state width, default PAT_W/GAP_CYC/REP_W constants, PREAMBLE constant.
- Sub-module seq_tx_shreg: parameterised PAT_W left-shift register with load, shift and serial-out MSB. The FSM, counters and holding registers stay in seq_pattern_tx.

Test Plan:
1. R=0 pulse asynchronously mid-cycle with outputs active → w, Valid, Busy, Done all 0 before the next posedge; state IDLE.
2. Pattern=8'b0000_1011, Len=4, Reps=0, Start one cycle → w=1,0,1,1 on 4 consecutive cycles with Valid=1; Done pulses on cycle 5; Busy low afterwards.
3. Pattern=8'hA5, Len=0 (→8), Reps=2, GAP_CYC=2 → 3×(1010_0101), each separated by 2 cycles of w=0/Valid=0; Done after 8*3+2*2+1=29 cycles.
4. Start re-asserted and Pattern changed while Busy → output is unchanged from the original frame; after Done plus one IDLE cycle with Start=1, the new frame starts.
5. Abort=1 on the 3rd bit of a Len=8 frame → next edge IDLE, w=0, Valid=0, no Done; a subsequent Start works normally.
6. With SEQ_TX_PREAMBLE_EN, Len=3 Pattern=3'b111 Reps=1 GAP_CYC=0 → w=1,0,1,1,1,1,0,1,1,1, Valid high throughout; Done on cycle 11.
